sequence_generator_101001_err_inject: RTL and testbench

Serial pattern transmitter that drives the 101001 sequence, MSB first, one bit per clock into the shift-register sequence detectors. Each start request sends a programmable number of frames with a programmable idle gap between them. A per-frame bit-flip mask injects errors, so the detector's error-tolerance boundary can be exercised. The block also reports how many bits it flipped and whether a tolerant detector should still hit.

---
 rtl/sequence_generator_101001_err_inject_if.sv | 33 +++
 rtl/sequence_generator_101001_err_inject.sv | 145 ++++++++++++++
 tb/tb_sequence_generator_101001_err_inject.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequence_generator_101001_err_inject_if.sv
// Bus bundle for the 101001 serial pattern generator.
// Handshake: o_valid qualifies o_data for one clock; there is no ready/backpressure,
// so the sink must take every bit on the cycle o_valid=1. i_start is a request that is
// only honoured while the generator is idle (o_busy=0); no acknowledge is returned
// other than o_busy rising in the following cycle.
interface sequence_generator_101001_err_inject_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
);
  localparam int ERR_W = $clog2(WIDTH + 1);

  logic             i_start;
  logic [WIDTH-1:0] i_err_mask;
  logic [CNT_W-1:0] i_repeat;
  logic [GAP_W-1:0] i_gap;
  logic             o_data;
  logic             o_valid;
  logic             o_busy;
  logic             o_done;
  logic [ERR_W-1:0] o_err_count;
  logic             o_expect_hit;

  modport master (
    output i_start, i_err_mask, i_repeat, i_gap,
    input  o_data, o_valid, o_busy, o_done, o_err_count, o_expect_hit
  );

  modport slave (
    input  i_start, i_err_mask, i_repeat, i_gap,
    output o_data, o_valid, o_busy, o_done, o_err_count, o_expect_hit
  );
endinterface

// File: rtl/sequence_generator_101001_err_inject.sv
// Serial transmitter of a fixed pattern (MSB first) with per-frame bit-flip injection,
// programmable frame repeat and inter-frame idle gap. Reports the number of flipped
// bits and whether a detector tolerating MAX_ERR errors should still match.
module sequence_generator_101001_err_inject #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] PATTERN = 6'b101001,
  parameter int               MAX_ERR = 2,
  parameter int               CNT_W   = 4,
  parameter int               GAP_W   = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  sequence_generator_101001_err_inject_if.slave bus,
  output logic [1:0] o_dbg_state
);
  localparam int ERR_W = $clog2(WIDTH + 1);
  localparam int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0]    LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [ERR_W-1:0] MAX_ERR_C = ERR_W'(MAX_ERR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             hit_q, hit_d;
  logic [ERR_W-1:0] mask_pop;
  logic [WIDTH-1:0] frame_img;

  // Popcount of the incoming mask, used only when a start is accepted.
  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_pop = mask_pop + ERR_W'(bus.i_err_mask[i]);
    end
  end

  assign frame_img = PATTERN ^ mask_q;

  // Register bank: FSM state, shifter, counters and latched transfer settings.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      mask_q    <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      err_q     <= '0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      mask_q    <= mask_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hit_q     <= hit_d;
    end
  end

  // Next-state and datapath: start latching, bit shifting, frame reload and gap timing.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    mask_d    = mask_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    err_d     = err_q;
    hit_d     = hit_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          mask_d  = bus.i_err_mask;
          gap_d   = bus.i_gap;
          sreg_d  = PATTERN ^ bus.i_err_mask;
          bit_d   = LAST_BIT;
          frame_d = (bus.i_repeat == '0) ? CNT_W'(1) : bus.i_repeat;
          err_d   = mask_pop;
          hit_d   = (mask_pop <= MAX_ERR_C);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = sreg_q << 1;
        if (bit_q == '0) begin
          // Frame counter saturates at zero rather than wrapping.
          frame_d = (frame_q != '0) ? frame_q - CNT_W'(1) : '0;
          if (frame_q > CNT_W'(1)) begin
            if (gap_q == '0) begin
              sreg_d = frame_img;
              bit_d  = LAST_BIT;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = GAP;
            end
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      GAP: begin
        // gap_cnt starts at the gap length, so exactly that many idle cycles elapse.
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          sreg_d    = frame_img;
          bit_d     = LAST_BIT;
          state_d   = SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_valid      = (state_q == SHIFT);
  assign bus.o_data       = (state_q == SHIFT) & sreg_q[WIDTH-1];
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_done       = done_q;
  assign bus.o_err_count  = err_q;
  assign bus.o_expect_hit = hit_q;
  assign o_dbg_state      = state_q;
endmodule

// File: tb/tb_sequence_generator_101001_err_inject.sv
// Directed bench for the 101001 pattern generator with error injection.
module tb_sequence_generator_101001_err_inject;
  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];   // {valid, data} per cycle

  sequence_generator_101001_err_inject_if #(.WIDTH(6), .CNT_W(4), .GAP_W(3)) bus ();

  sequence_generator_101001_err_inject dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset block
  always #5 i_clk = ~i_clk;

  // Driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Presents a start for one edge, then scrambles the inputs to show they were latched.
  task automatic start_xfer(input logic [5:0] mask, input logic [3:0] rep, input logic [2:0] gap);
    bus.i_start    = 1'b1;
    bus.i_err_mask = mask;
    bus.i_repeat   = rep;
    bus.i_gap      = gap;
    tick();
    bus.i_start    = 1'b0;
    bus.i_err_mask = 6'($urandom_range(0, 63));
    bus.i_repeat   = 4'($urandom_range(0, 15));
    bus.i_gap      = 3'($urandom_range(0, 7));
  endtask

  task automatic push_frame(input logic [5:0] bits);
    for (int i = 5; i >= 0; i--) exp_q.push_back({1'b1, bits[i]});
  endtask

  task automatic push_gap(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    bus.i_start = 1'b0; bus.i_err_mask = '0; bus.i_repeat = '0; bus.i_gap = '0;
    tick(); tick();
    checks++;
    if ({bus.o_data, bus.o_valid, bus.o_busy, bus.o_done, bus.o_err_count, bus.o_expect_hit, dbg_state} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got d=%b v=%b b=%b dn=%b e=%0d h=%b s=%0d want all 0",
               bus.o_data, bus.o_valid, bus.o_busy, bus.o_done, bus.o_err_count, bus.o_expect_hit, dbg_state);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_clean_frame();
    logic [1:0] e;
    int cyc;
    push_frame(6'b101001);
    start_xfer(6'b000000, 4'd1, 3'd0);
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e || bus.o_busy !== 1'b1) begin
        failures++;
        $display("FAIL clean_stream cyc=k+%0d got v/d=%b busy=%b want %b busy=1", cyc, {bus.o_valid, bus.o_data}, bus.o_busy, e);
      end
      tick(); cyc++;
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_data !== 1'b0) begin
      failures++;
      $display("FAIL clean_done cyc=k+%0d got done=%b busy=%b v=%b d=%b want 1 0 0 0", cyc, bus.o_done, bus.o_busy, bus.o_valid, bus.o_data);
    end
    checks++;
    if (bus.o_err_count !== 3'd0 || bus.o_expect_hit !== 1'b1) begin
      failures++;
      $display("FAIL clean_err got cnt=%0d hit=%b want 0 1", bus.o_err_count, bus.o_expect_hit);
    end
    tick();
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_err_count !== 3'd0 || bus.o_expect_hit !== 1'b1) begin
      failures++;
      $display("FAIL done_pulse_hold got done=%b cnt=%0d hit=%b want 0 0 1", bus.o_done, bus.o_err_count, bus.o_expect_hit);
    end
  endtask

  // Two-bit error, then a three-bit error started in the done cycle of the first.
  task automatic test_error_frames();
    logic [1:0] e;
    push_frame(6'b101111);
    start_xfer(6'b000110, 4'd1, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e) begin
        failures++;
        $display("FAIL err2_stream got v/d=%b want %b", {bus.o_valid, bus.o_data}, e);
      end
      tick();
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_err_count !== 3'd2 || bus.o_expect_hit !== 1'b1) begin
      failures++;
      $display("FAIL err2_done got done=%b cnt=%0d hit=%b want 1 2 1", bus.o_done, bus.o_err_count, bus.o_expect_hit);
    end
    push_frame(6'b101110);
    start_xfer(6'b000111, 4'd1, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e || bus.o_busy !== 1'b1) begin
        failures++;
        $display("FAIL err3_stream got v/d=%b busy=%b want %b busy=1", {bus.o_valid, bus.o_data}, bus.o_busy, e);
      end
      tick();
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_err_count !== 3'd3 || bus.o_expect_hit !== 1'b0) begin
      failures++;
      $display("FAIL err3_done got done=%b cnt=%0d hit=%b want 1 3 0", bus.o_done, bus.o_err_count, bus.o_expect_hit);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] e;
    int cyc;
    push_frame(6'b101001); push_frame(6'b101001); push_frame(6'b101001);
    start_xfer(6'b000000, 4'd3, 3'd0);
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e || bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stream cyc=k+%0d got v/d=%b busy=%b done=%b want %b 1 0", cyc, {bus.o_valid, bus.o_data}, bus.o_busy, bus.o_done, e);
      end
      tick(); cyc++;
    end
    checks++;
    if (cyc != 19 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done cyc=k+%0d got done=%b busy=%b want k+19 1 0", cyc, bus.o_done, bus.o_busy);
    end
    tick();
  endtask

  task automatic test_gap_and_repeat0();
    logic [1:0] e;
    int cyc;
    push_frame(6'b101001); push_gap(2); push_frame(6'b101001);
    start_xfer(6'b000000, 4'd2, 3'd2);
    cyc = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e || bus.o_busy !== 1'b1) begin
        failures++;
        $display("FAIL gap_stream cyc=k+%0d got v/d=%b busy=%b want %b busy=1", cyc, {bus.o_valid, bus.o_data}, bus.o_busy, e);
      end
      tick(); cyc++;
    end
    checks++;
    if (cyc != 15 || bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_done cyc=k+%0d got done=%b busy=%b want k+15 1 0", cyc, bus.o_done, bus.o_busy);
    end
    tick();
    // repeat=0 sends one frame; a nonzero gap must not add trailing idle cycles
    push_frame(6'b001001);
    start_xfer(6'b100000, 4'd0, 3'd5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e) begin
        failures++;
        $display("FAIL rep0_stream got v/d=%b want %b", {bus.o_valid, bus.o_data}, e);
      end
      tick();
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_err_count !== 3'd1 || bus.o_expect_hit !== 1'b1) begin
      failures++;
      $display("FAIL rep0_done got done=%b busy=%b cnt=%0d hit=%b want 1 0 1 1", bus.o_done, bus.o_busy, bus.o_err_count, bus.o_expect_hit);
    end
    tick();
  endtask

  task automatic test_busy_start_and_reset();
    logic [1:0] e;
    logic [5:0] clean;
    clean = 6'b101001;
    start_xfer(6'b000000, 4'd1, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if ({bus.o_valid, bus.o_data} !== {1'b1, clean[6-c]}) begin
        failures++;
        $display("FAIL busy_pre cyc=k+%0d got v/d=%b want %b", c, {bus.o_valid, bus.o_data}, {1'b1, clean[6-c]});
      end
      if (c == 3) begin
        bus.i_start = 1'b1; bus.i_err_mask = 6'b111111; bus.i_repeat = 4'd5;
      end
      tick();
    end
    bus.i_start = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_data} !== 2'b10 || bus.o_err_count !== 3'd0 || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore got v/d=%b cnt=%0d busy=%b want 10 0 1", {bus.o_valid, bus.o_data}, bus.o_err_count, bus.o_busy);
    end
    i_reset = 1'b1;
    #1;
    checks++;
    if ({bus.o_data, bus.o_valid, bus.o_busy, bus.o_done, bus.o_err_count, bus.o_expect_hit, dbg_state} !== 10'b0) begin
      failures++;
      $display("FAIL async_reset got d=%b v=%b b=%b dn=%b e=%0d h=%b s=%0d want all 0",
               bus.o_data, bus.o_valid, bus.o_busy, bus.o_done, bus.o_err_count, bus.o_expect_hit, dbg_state);
    end
    tick();
    i_reset = 1'b0;
    push_frame(6'b101001);
    start_xfer(6'b000000, 4'd1, 3'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.o_valid, bus.o_data} !== e) begin
        failures++;
        $display("FAIL post_reset_stream got v/d=%b want %b", {bus.o_valid, bus.o_data}, e);
      end
      tick();
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_expect_hit !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_done got done=%b hit=%b want 1 1", bus.o_done, bus.o_expect_hit);
    end
    tick();
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_clean_frame();
    test_error_frames();
    test_back_to_back();
    test_gap_and_repeat0();
    test_busy_start_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
